// File: rtl/sme_prng_arbiter_if.sv
// Requester/TRNG/LFSR side-band bundle for the shared-PRNG arbiter.
// The arbiter sits on the slave modport; the requester/LFSR side is the master.
interface sme_prng_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [31:0]     rdata;
  logic            busy;
  logic            trng_valid;
  logic            trng_bit;
  logic            trng_ready;
  logic            lfsr_update;
  logic            lfsr_extra_tap;
  logic [31:0]     lfsr_prng;

  modport master (
    output req, trng_valid, trng_bit, lfsr_prng,
    input  gnt, rdata, busy, trng_ready, lfsr_update, lfsr_extra_tap
  );
  modport slave (
    input  req, trng_valid, trng_bit, lfsr_prng,
    output gnt, rdata, busy, trng_ready, lfsr_update, lfsr_extra_tap
  );
endinterface

// File: rtl/sme_prng_arbiter.sv
// Round-robin arbiter handing out single-use values from one shared LFSR,
// stepping it between grants and periodically reseeding it from a TRNG.
module sme_prng_arbiter #(
  parameter int NREQ          = 4,
  parameter int STEPS         = 2,
  parameter int RESEED_PERIOD = 256,
  parameter int RESEED_BITS   = 32
) (
  input  logic              g_clk,
  input  logic              g_reset,
  sme_prng_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STEPS + 1);
  localparam int GW = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;
  localparam int BW = $clog2(RESEED_BITS + 1);

  typedef enum logic [1:0] {S_IDLE, S_STEP, S_RESEED} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_rr_ptr, w_rr_nxt, w_win;
  logic            w_found;
  logic [SW-1:0]   r_step_cnt, w_step_nxt;
  logic [GW-1:0]   r_grant_cnt, w_grant_nxt;
  logic [BW-1:0]   r_bit_cnt, w_bit_nxt;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic [31:0]     r_rdata, w_rdata_nxt;
  logic            w_update, w_tap, w_ready;

  // Search starts at rr_ptr and wraps, so the last winner has lowest priority.
  always_comb begin
    int j;
    j       = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!w_found && bus.req[PW'(j)]) begin
        w_found = 1'b1;
        w_win   = PW'(j);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_step_nxt  = r_step_cnt;
    w_grant_nxt = r_grant_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_gnt_nxt   = '0;
    w_rdata_nxt = r_rdata;
    w_update    = 1'b0;
    w_tap       = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt   = NREQ'(1) << w_win;
          w_rdata_nxt = bus.lfsr_prng;
          w_rr_nxt    = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
          if (RESEED_PERIOD != 0) w_grant_nxt = r_grant_cnt + 1'b1;
          w_step_nxt  = '0;
          w_state_nxt = S_STEP;
        end
      end
      S_STEP: begin
        w_update = 1'b1;
        if (r_step_cnt == SW'(STEPS - 1)) begin
          w_step_nxt = '0;
          if (RESEED_PERIOD != 0 && r_grant_cnt == GW'(RESEED_PERIOD))
            w_state_nxt = S_RESEED;
          else
            w_state_nxt = S_IDLE;
        end else begin
          w_step_nxt = r_step_cnt + 1'b1;
        end
      end
      S_RESEED: begin
        // Each TRNG bit is folded in through one LFSR step via extra_tap.
        w_ready  = 1'b1;
        w_update = bus.trng_valid;
        w_tap    = bus.trng_valid & bus.trng_bit;
        if (bus.trng_valid) begin
          if (r_bit_cnt == BW'(RESEED_BITS - 1)) begin
            w_bit_nxt   = '0;
            w_grant_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_step_cnt  <= '0;
      r_grant_cnt <= '0;
      r_bit_cnt   <= '0;
      r_gnt       <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_step_cnt  <= w_step_nxt;
      r_grant_cnt <= w_grant_nxt;
      r_bit_cnt   <= w_bit_nxt;
      r_gnt       <= w_gnt_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

  assign bus.gnt            = r_gnt;
  assign bus.rdata          = r_rdata;
  assign bus.busy           = (r_state != S_IDLE);
  assign bus.trng_ready     = w_ready;
  assign bus.lfsr_update    = w_update;
  assign bus.lfsr_extra_tap = w_tap;
endmodule

// File: tb/tb_sme_prng_arbiter.sv
// Bench for sme_prng_arbiter: directed scenarios plus a randomized run
// against an abstract work-remaining model of the arbiter.
module tb_sme_prng_arbiter;
  localparam int N = 4;
  localparam logic [31:0] K = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] t_req = '0;
  logic         t_tv = 1'b0;
  logic         t_tb = 1'b0;
  logic [31:0]  prng_a = 32'h0;
  logic [31:0]  prng_b = 32'h0;
  int           n_run = 0;
  int           n_fail = 0;

  always #5 clk = ~clk;

  sme_prng_arbiter_if #(.NREQ(N)) if_a ();
  sme_prng_arbiter_if #(.NREQ(N)) if_b ();

  assign if_a.req = t_req;      assign if_b.req = t_req;
  assign if_a.trng_valid = t_tv; assign if_b.trng_valid = t_tv;
  assign if_a.trng_bit = t_tb;   assign if_b.trng_bit = t_tb;
  assign if_a.lfsr_prng = prng_a;
  assign if_b.lfsr_prng = prng_b;

  sme_prng_arbiter #(.NREQ(N), .STEPS(2), .RESEED_PERIOD(256), .RESEED_BITS(32)) dut_a (
    .g_clk(clk), .g_reset(rst), .bus(if_a.slave));
  sme_prng_arbiter #(.NREQ(N), .STEPS(2), .RESEED_PERIOD(2), .RESEED_BITS(32)) dut_b (
    .g_clk(clk), .g_reset(rst), .bus(if_b.slave));

  // Stand-in LFSRs: advance by an odd constant on each update, so values never repeat.
  task automatic tick();
    logic ua, ub;
    ua = if_a.lfsr_update;
    ub = if_b.lfsr_update;
    @(posedge clk);
    @(negedge clk);
    if (ua) prng_a = prng_a + K;
    if (ub) prng_b = prng_b + K;
  endtask

  task automatic do_reset();
    rst = 1'b1; t_req = '0; t_tv = 1'b0; t_tb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; t_req = '0; t_tv = 1'b1; t_tb = 1'b1;
    #3;
    n_run++;
    if ({if_a.gnt, if_a.rdata, if_a.busy, if_a.trng_ready, if_a.lfsr_update, if_a.lfsr_extra_tap} !== '0) begin
      n_fail++;
      $display("FAIL reset_a: got gnt=%b rdata=%h busy=%b rdy=%b upd=%b tap=%b want all 0",
               if_a.gnt, if_a.rdata, if_a.busy, if_a.trng_ready, if_a.lfsr_update, if_a.lfsr_extra_tap);
    end
    n_run++;
    if ({if_b.gnt, if_b.rdata, if_b.busy, if_b.trng_ready, if_b.lfsr_update} !== '0) begin
      n_fail++;
      $display("FAIL reset_b: got gnt=%b rdata=%h busy=%b rdy=%b upd=%b want all 0",
               if_b.gnt, if_b.rdata, if_b.busy, if_b.trng_ready, if_b.lfsr_update);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    prng_a = 32'h6789ABCD; t_req = 4'b0010; #1;
    tick(); t_req = '0; #1;
    n_run++;
    if ({if_a.gnt, if_a.rdata, if_a.lfsr_update} !== {4'b0010, 32'h6789ABCD, 1'b1}) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b rdata=%h upd=%b want 0010 6789abcd 1",
               if_a.gnt, if_a.rdata, if_a.lfsr_update);
    end
    tick(); #1;
    n_run++;
    if ({if_a.gnt, if_a.lfsr_update, if_a.busy} !== {4'b0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL single_step2: got gnt=%b upd=%b busy=%b want 0000 1 1",
               if_a.gnt, if_a.lfsr_update, if_a.busy);
    end
    tick(); #1;
    n_run++;
    if ({if_a.gnt, if_a.lfsr_update, if_a.busy} !== '0) begin
      n_fail++;
      $display("FAIL single_idle: got gnt=%b upd=%b busy=%b want 0000 0 0",
               if_a.gnt, if_a.lfsr_update, if_a.busy);
    end
  endtask

  task automatic test_round_robin();
    logic [31:0] seen[$];
    logic [N-1:0] exp_g;
    int dup;
    do_reset();
    t_req = 4'b1111; #1;
    for (int c = 1; c <= 14; c++) begin
      tick(); #1;
      exp_g = (c % 3 == 1) ? (N'(1) << (((c - 1) / 3) % N)) : '0;
      n_run++;
      if (if_a.gnt !== exp_g) begin
        n_fail++;
        $display("FAIL rr_gnt c=%0d: got %b want %b", c, if_a.gnt, exp_g);
      end
      if (if_a.gnt != '0) seen.push_back(if_a.rdata);
    end
    dup = 0;
    foreach (seen[i]) for (int j = i + 1; j < seen.size(); j++) if (seen[i] == seen[j]) dup++;
    n_run++;
    if (seen.size() != 5 || dup != 0) begin
      n_fail++;
      $display("FAIL rr_distinct: got %0d grants %0d duplicates want 5 grants 0 duplicates", seen.size(), dup);
    end
    t_req = '0;
  endtask

  task automatic test_withdraw();
    do_reset();
    t_req = 4'b0001; #1;
    tick(); t_req = 4'b0100; #1;
    n_run++;
    if (if_a.gnt !== 4'b0001) begin
      n_fail++; $display("FAIL wd_first: got %b want 0001", if_a.gnt);
    end
    tick(); t_req = '0; #1;
    tick(); #1;
    n_run++;
    if ({if_a.gnt, if_a.busy} !== '0) begin
      n_fail++; $display("FAIL wd_dropped: got gnt=%b busy=%b want 0000 0", if_a.gnt, if_a.busy);
    end
    t_req = 4'b0100; #2; t_req = '0;
    tick(); #1;
    n_run++;
    if ({if_a.gnt, if_a.busy} !== '0) begin
      n_fail++; $display("FAIL wd_pulse: got gnt=%b busy=%b want 0000 0", if_a.gnt, if_a.busy);
    end
    t_req = 4'b1111; #1;
    tick(); #1;
    n_run++;
    if (if_a.gnt !== 4'b0010) begin
      n_fail++; $display("FAIL wd_ptr: got %b want 0010", if_a.gnt);
    end
    t_req = '0;
  endtask

  task automatic test_reseed_full();
    logic [N-1:0] exp_g;
    logic in_rs, step;
    do_reset();
    t_req = 4'b1111; t_tv = 1'b1; t_tb = 1'b1; #1;
    for (int c = 1; c <= 40; c++) begin
      tick(); #1;
      in_rs = (c >= 6 && c <= 37);
      step  = (c == 1 || c == 2 || c == 4 || c == 5 || c >= 39);
      exp_g = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 39) ? 4'b0100 : 4'b0000;
      n_run++;
      if ({if_b.gnt, if_b.trng_ready, if_b.lfsr_update, if_b.lfsr_extra_tap} !== {exp_g, in_rs, in_rs | step, in_rs}) begin
        n_fail++;
        $display("FAIL reseed c=%0d: got gnt=%b rdy=%b upd=%b tap=%b want %b %b %b %b", c,
                 if_b.gnt, if_b.trng_ready, if_b.lfsr_update, if_b.lfsr_extra_tap,
                 exp_g, in_rs, in_rs | step, in_rs);
      end
    end
    t_req = '0; t_tv = 1'b0;
  endtask

  task automatic test_reseed_toggle();
    int rs_cyc, bits;
    logic step;
    logic [N-1:0] exp_g;
    do_reset();
    rs_cyc = 0; bits = 0;
    t_req = 4'b1111; t_tv = 1'b0; #1;
    for (int c = 1; c <= 73; c++) begin
      tick();
      t_tv = (c % 2 == 1);
      t_tb = 1'($urandom);
      #1;
      step  = (c == 1 || c == 2 || c == 4 || c == 5 || c == 71 || c == 72);
      exp_g = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0010 : (c == 71) ? 4'b0100 : 4'b0000;
      if (if_b.trng_ready) begin
        rs_cyc++;
        if (t_tv) bits++;
      end
      n_run++;
      if ({if_b.gnt, if_b.lfsr_update, if_b.lfsr_extra_tap} !==
          {exp_g, step | (if_b.trng_ready & t_tv), if_b.trng_ready & t_tv & t_tb}) begin
        n_fail++;
        $display("FAIL toggle c=%0d: got gnt=%b upd=%b tap=%b rdy=%b want gnt=%b", c,
                 if_b.gnt, if_b.lfsr_update, if_b.lfsr_extra_tap, if_b.trng_ready, exp_g);
      end
    end
    n_run++;
    if (rs_cyc != 64 || bits != 32) begin
      n_fail++;
      $display("FAIL toggle_len: got %0d cycles %0d bits want 64 cycles 32 bits", rs_cyc, bits);
    end
    t_req = '0; t_tv = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    t_req = 4'b1111; t_tv = 1'b1; t_tb = 1'b1; #1;
    for (int c = 1; c <= 16; c++) begin
      tick(); #1;
    end
    n_run++;
    if (if_b.trng_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_in_reseed: got rdy=%b want 1", if_b.trng_ready);
    end
    rst = 1'b1; #1;
    n_run++;
    if ({if_b.gnt, if_b.rdata, if_b.busy, if_b.trng_ready, if_b.lfsr_update, if_b.lfsr_extra_tap} !== '0) begin
      n_fail++;
      $display("FAIL mid_async: got gnt=%b rdata=%h busy=%b rdy=%b upd=%b tap=%b want all 0",
               if_b.gnt, if_b.rdata, if_b.busy, if_b.trng_ready, if_b.lfsr_update, if_b.lfsr_extra_tap);
    end
    @(negedge clk);
    rst = 1'b0; t_req = 4'b0010; t_tv = 1'b0; prng_b = 32'h6789ABCD; #1;
    tick(); #1;
    n_run++;
    if ({if_b.gnt, if_b.rdata} !== {4'b0010, 32'h6789ABCD}) begin
      n_fail++; $display("FAIL mid_regrant: got gnt=%b rdata=%h want 0010 6789abcd", if_b.gnt, if_b.rdata);
    end
    tick(); tick(); #1;
    n_run++;
    if ({if_b.busy, if_b.trng_ready} !== 2'b00) begin
      n_fail++; $display("FAIL mid_no_reseed: got busy=%b rdy=%b want 0 0", if_b.busy, if_b.trng_ready);
    end
    tick(); #1;
    n_run++;
    if (if_b.gnt !== 4'b0010) begin
      n_fail++; $display("FAIL mid_second: got %b want 0010", if_b.gnt);
    end
    tick(); tick(); #1;
    n_run++;
    if (if_b.trng_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_period: got rdy=%b want 1", if_b.trng_ready);
    end
    t_req = '0;
  endtask

  task automatic test_random();
    int m_step, m_bits, m_ptr, m_gcnt, w, dup;
    logic found, e_rdy;
    logic [N-1:0] m_gnt;
    logic [31:0] m_rdata;
    logic [31:0] seen[$];
    do_reset();
    m_step = 0; m_bits = 0; m_ptr = 0; m_gcnt = 0; m_gnt = '0; m_rdata = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom % 4 == 0) t_req = N'($urandom);
      t_tv = ($urandom % 3 != 0);
      t_tb = 1'($urandom);
      #1;
      e_rdy = (m_step == 0 && m_bits > 0);
      n_run++;
      if ({if_b.gnt, if_b.busy, if_b.trng_ready, if_b.lfsr_update, if_b.lfsr_extra_tap} !==
          {m_gnt, (m_step > 0 || m_bits > 0), e_rdy, (m_step > 0) | (e_rdy & t_tv), e_rdy & t_tv & t_tb} ||
          (m_gnt != '0 && if_b.rdata !== m_rdata)) begin
        n_fail++;
        $display("FAIL rand c=%0d: got gnt=%b rdata=%h busy=%b rdy=%b upd=%b want gnt=%b rdata=%h step=%0d bits=%0d",
                 c, if_b.gnt, if_b.rdata, if_b.busy, if_b.trng_ready, if_b.lfsr_update,
                 m_gnt, m_rdata, m_step, m_bits);
      end
      if (m_gnt != '0) seen.push_back(if_b.rdata);
      m_gnt = '0;
      if (m_step > 0) begin
        m_step--;
        if (m_step == 0 && m_gcnt == 2) begin m_bits = 32; m_gcnt = 0; end
      end else if (m_bits > 0) begin
        if (t_tv) m_bits--;
      end else if (t_req != '0) begin
        found = 1'b0; w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && t_req[2'((m_ptr + k) % N)]) begin found = 1'b1; w = (m_ptr + k) % N; end
        end
        m_gnt = N'(1) << w; m_rdata = prng_b; m_ptr = (w + 1) % N; m_step = 2; m_gcnt++;
      end
      tick();
    end
    dup = 0;
    foreach (seen[i]) for (int j = i + 1; j < seen.size(); j++) if (seen[i] == seen[j]) dup++;
    n_run++;
    if (dup != 0 || seen.size() < 10) begin
      n_fail++; $display("FAIL rand_unique: got %0d grants %0d duplicates want >=10 grants 0 duplicates", seen.size(), dup);
    end
    t_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_withdraw();
    test_reseed_full();
    test_reseed_toggle();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
